// File: rtl/fetch_decode_stage.sv
// Fetch stage PC register plus the IF/ID pipeline register, with redirect
// handling for jumps/branches resolved in decode and saturating stall/flush counters.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  logic [31:0] pcPlus4F;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic [31:0] pcNext;
  logic        clrD;

  // Jump outranks branch; a stalled decode stage must not be cleared.
  always_comb begin
    pcPlus4F     = PCF + 32'd4;
    jumpTarget   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
    branchTarget = {PCBranchD[31:2], 2'b00};
    clrD         = (PCSrcD | JumpD) & ~StallD;
    pcNext       = pcPlus4F;
    if (JumpD) begin
      pcNext = jumpTarget;
    end else if (PCSrcD) begin
      pcNext = branchTarget;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= pcNext;
    end
  end

  // Stall holds the IF/ID register even when a clear is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (clrD) begin
        InstrD   <= 32'h0;
        PCPlus4D <= 32'h0;
        ValidD   <= 1'b0;
      end else begin
        InstrD   <= InstrF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= 16'h0;
      FlushCount <= 16'h0;
    end else begin
      if (StallF && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
      if (clrD && (FlushCount != 16'hFFFF)) begin
        FlushCount <= FlushCount + 16'd1;
      end
    end
  end

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset (bits [1:0] SHALL be 0).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 StallF  input  1  from hazard unit; hold PC register.
REQ-005 StallD  input  1  from hazard unit; hold IF/ID register.
REQ-006 PCSrcD  input  1  branch taken, resolved in D.
REQ-007 JumpD  input  1  jump instruction in D.
REQ-008 PCBranchD  input  32  branch target computed in D.
REQ-009 InstrF  input  32  instruction memory read data at address PCF.
REQ-010 PCF  output  32  current fetch address, registered.
REQ-011 InstrD  output  32  instruction in D, registered.
REQ-012 PCPlus4D  output  32  PC+4 of instruction in D, registered.
REQ-013 ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).
REQ-014 StallCount  output  16  saturating count of cycles with StallF=1.
REQ-015 FlushCount  output  16  saturating count of IF/ID clear events.

Function
REQ-016 PCPlus4F SHALL be PCF+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 Jump target SHALL be {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
REQ-018 Next PC priority SHALL be: JumpD -> jump target; else PCSrcD -> {PCBranchD[31:2],2'b00}; else PCPlus4F.
REQ-019 On each rising clk with StallF=1, PCF SHALL hold; redirect inputs ignored that cycle.
REQ-020 On each rising clk with StallF=0, PCF SHALL load next PC per REQ-018 (1-cycle redirect latency).
REQ-021 ClrD SHALL be defined as (PCSrcD | JumpD) & ~StallD.
REQ-022 With StallD=1, InstrD, PCPlus4D, ValidD SHALL hold (stall overrides clear).
REQ-023 With StallD=0 and ClrD=1, next cycle InstrD=32'h0, PCPlus4D=32'h0, ValidD=0.
REQ-024 With StallD=0 and ClrD=0, next cycle InstrD=InstrF, PCPlus4D=PCPlus4F, ValidD=1.
REQ-025 StallF=0 with StallD=1 is legal; PC advances while IF/ID holds, no error flagged.
REQ-026 JumpD and PCSrcD both 1: jump target wins; single clear, FlushCount +1.
REQ-027 StallCount SHALL increment by 1 per cycle with StallF=1, saturating at 16'hFFFF.
REQ-028 FlushCount SHALL increment by 1 per cycle with ClrD=1, saturating at 16'hFFFF.
REQ-029 All outputs SHALL be registers; no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 SHALL immediately (no clock edge) force PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, StallCount=0, FlushCount=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard pending redirect; first edge after release fetches from RESET_PC+4 path per REQ-020.
REQ-032 While rst=1, clock edges SHALL NOT change state.

Verification
REQ-033 Reset release, StallF=StallD=PCSrcD=JumpD=0, InstrF=32'h2008_0005 -> PCF 0,4,8; after edge 1 InstrD=32'h2008_0005, PCPlus4D=4, ValidD=1.
REQ-034 PCF=32'h10, StallF=StallD=1 for 3 cycles -> PCF stays 32'h10, InstrD unchanged, StallCount=3, FlushCount=0.
REQ-035 PCSrcD=1, PCBranchD=32'h40, stalls 0 -> next PCF=32'h40, InstrD=0, ValidD=0, FlushCount+1.
REQ-036 JumpD=1, InstrD=32'h0800_0020, PCPlus4D=32'h1000_0008 -> next PCF=32'h1000_0080, ValidD=0.
REQ-037 PCSrcD=1 with StallF=StallD=1 -> PCF, InstrD hold, FlushCount unchanged, StallCount+1.
REQ-038 RESET_PC=32'hFFFF_FFFC, no stalls -> PCF wraps to 32'h0; StallCount preset near 16'hFFFF via long stall saturates, no wrap.
